// File: rtl/mmio_sw_led_ctrl_if.sv
// CPU data-bus bundle for the switch/LED peripheral.
// The master drives the address and strobes; the slave returns registered read data.
interface mmio_sw_led_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              rd_vld;

  modport master (output addr, we, re, wdata, input rdata, rd_vld);
  modport slave  (input addr, we, re, wdata, output rdata, rd_vld);
endinterface

// File: rtl/mmio_sw_led_ctrl.sv
// Memory-mapped switch/LED peripheral: synchronised, debounced switches, LED register with set/toggle.
// Optional change interrupt is enabled by defining SW_CHANGE_IRQ_EN.
module mmio_sw_led_ctrl #(
  parameter int                SW_W      = 10,
  parameter int                LED_W     = 10,
  parameter int                DB_CYCLES = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hC000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmio_sw_led_ctrl_if.slave    bus,
  input  logic [SW_W-1:0]      sw,
  output logic [LED_W-1:0]     led,
  output logic                 irq
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [SW_W-1:0]   s1, s2, cand, stable;
  logic [CW-1:0]     cnt;
  logic              chg;
  logic              ie;
  logic [ADDR_W-1:0] off;
  logic              hit, wr, rd, accept;
  logic [15:0]       rmux;
  logic              unused_wdata;

  // Below-base addresses wrap to large offsets and therefore miss.
  assign off    = bus.addr - BASE_ADDR;
  assign hit    = (off < ADDR_W'(4));
  assign wr     = bus.we & hit;
  assign rd     = bus.re & hit;
  assign accept = (s2 == cand) && (cand != stable) && (cnt == CW'(DB_CYCLES - 1));
  assign unused_wdata = ^bus.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      cand <= s2;
      if (s2 != cand) begin
        cnt <= '0;
      end else if (cand != stable) begin
        if (cnt == CW'(DB_CYCLES - 1)) begin
          stable <= cand;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else if (wr && off[1:0] == 2'd1) begin
      led <= bus.wdata[LED_W-1:0];
    end else if (wr && off[1:0] == 2'd3) begin
      led <= led ^ bus.wdata[LED_W-1:0];
    end
  end

  // A debounce acceptance beats a simultaneous write-1-clear so no change is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg <= 1'b0;
    end else if (accept) begin
      chg <= 1'b1;
    end else if (wr && off[1:0] == 2'd2 && bus.wdata[0]) begin
      chg <= 1'b0;
    end
  end

`ifdef SW_CHANGE_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr && off[1:0] == 2'd2) begin
        ie <= bus.wdata[1];
      end
      irq <= chg & ie;
    end
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  always_comb begin
    rmux = '0;
    case (off[1:0])
      2'd0:    rmux = 16'(stable);
      2'd1:    rmux = 16'(led);
      2'd2:    rmux = {14'b0, ie, chg};
      default: rmux = '0;
    endcase
  end

  // Read data samples register state before this edge's writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata  <= '0;
      bus.rd_vld <= 1'b0;
    end else begin
      bus.rdata  <= rd ? rmux : 16'h0000;
      bus.rd_vld <= rd;
    end
  end

endmodule

// File: tb/tb_mmio_sw_led_ctrl.sv
// Self-checking bench for mmio_sw_led_ctrl: vector table for bus behaviour plus
// hand-written sequences for debounce, reset, W1C races and the optional irq.
module tb_mmio_sw_led_ctrl;

  localparam int          SW_W   = 10;
  localparam int          LED_W  = 10;
  localparam int          DB     = 4;
  localparam int          ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'hC000;
`ifdef SW_CHANGE_IRQ_EN
  localparam logic        EXP_IE = 1'b1;
`else
  localparam logic        EXP_IE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [SW_W-1:0]  sw;
  logic [LED_W-1:0] led;
  logic             irq;

  mmio_sw_led_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mmio_sw_led_ctrl #(
    .SW_W(SW_W), .LED_W(LED_W), .DB_CYCLES(DB), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sw(sw), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             we;
    logic             re;
    logic [15:0]      off;
    logic [15:0]      wdata;
    logic [15:0]      exp_rdata;
    logic             exp_vld;
    logic [LED_W-1:0] exp_led;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] rd;
  logic        vld;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic we, logic re, logic [15:0] off, logic [15:0] wd,
                              logic [15:0] er, logic ev, logic [LED_W-1:0] el);
    vec_t v;
    v.we = we; v.re = re; v.off = off; v.wdata = wd;
    v.exp_rdata = er; v.exp_vld = ev; v.exp_led = el;
    return v;
  endfunction

  // Every task starts at a falling edge, spans one rising edge and returns at the next falling edge.
  task automatic apply_stimulus(input vec_t v, input int idx);
    bus.we    = v.we;
    bus.re    = v.re;
    bus.addr  = BASE + v.off;
    bus.wdata = v.wdata;
    @(posedge clk); #1;
    check_output($sformatf("vec%0d_rdata", idx), bus.rdata, v.exp_rdata);
    check_output($sformatf("vec%0d_vld", idx), 16'(bus.rd_vld), 16'(v.exp_vld));
    check_output($sformatf("vec%0d_led", idx), 16'(led), 16'(v.exp_led));
    @(negedge clk);
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] off, input logic [15:0] d);
    bus.addr = BASE + off; bus.wdata = d; bus.we = 1'b1; bus.re = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] off, output logic [15:0] d, output logic v);
    bus.addr = BASE + off; bus.re = 1'b1; bus.we = 1'b0;
    @(posedge clk); #1;
    d = bus.rdata;
    v = bus.rd_vld;
    @(negedge clk);
    bus.re = 1'b0;
  endtask

  // Hold reset with sw applied, release, then watch SW_VAL continuously.
  task automatic reset_seq(input logic [SW_W-1:0] v, input string tag);
    logic [15:0] d;
    logic        ok;
    rst_n = 1'b0; sw = v;
    bus.addr = BASE; bus.re = 1'b1; bus.we = 1'b0; bus.wdata = '0;
    @(posedge clk); #1;
    check_output({tag, "_rst_led"}, 16'(led), 16'h0);
    check_output({tag, "_rst_rdata"}, bus.rdata, 16'h0);
    check_output({tag, "_rst_vld"}, 16'(bus.rd_vld), 16'h0);
    check_output({tag, "_rst_irq"}, 16'(irq), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 6) check_output({tag, "_swval_e6"}, bus.rdata, 16'h0);
      if (k == 8) check_output({tag, "_swval_e8"}, bus.rdata, 16'(v));
    end
    @(negedge clk);
    bus.re = 1'b0;
    bus_read(16'd2, d, ok);
    check_output({tag, "_chg"}, d, 16'h0001);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [SW_W-1:0] pats[10];
    logic            found;
    sw = '0;
    bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Register-map vectors, applied after the first reset leaves stable=0x2A5, CHG=1, led=0.
    vecs.push_back(mk(1, 0, 16'd1,    16'h0155, 16'h0000, 0, 10'h155));
    vecs.push_back(mk(1, 0, 16'd3,    16'h000F, 16'h0000, 0, 10'h15A));
    vecs.push_back(mk(0, 1, 16'd1,    16'h0000, 16'h015A, 1, 10'h15A));
    vecs.push_back(mk(0, 0, 16'd0,    16'h0000, 16'h0000, 0, 10'h15A));
    vecs.push_back(mk(0, 1, 16'd0,    16'h0000, 16'h02A5, 1, 10'h15A));
    vecs.push_back(mk(0, 1, 16'd2,    16'h0000, 16'h0001, 1, 10'h15A));
    vecs.push_back(mk(0, 1, 16'd3,    16'h0000, 16'h0000, 1, 10'h15A));
    vecs.push_back(mk(0, 1, 16'd4,    16'h0000, 16'h0000, 0, 10'h15A));
    vecs.push_back(mk(0, 1, 16'hFFFF, 16'h0000, 16'h0000, 0, 10'h15A));
    vecs.push_back(mk(1, 0, 16'd1,    16'hFFFF, 16'h0000, 0, 10'h3FF));
    vecs.push_back(mk(0, 1, 16'd1,    16'h0000, 16'h03FF, 1, 10'h3FF));
    vecs.push_back(mk(1, 0, 16'd0,    16'h0000, 16'h0000, 0, 10'h3FF));
    vecs.push_back(mk(0, 1, 16'd0,    16'h0000, 16'h02A5, 1, 10'h3FF));
    vecs.push_back(mk(1, 0, 16'd4,    16'h0000, 16'h0000, 0, 10'h3FF));
    vecs.push_back(mk(1, 1, 16'd1,    16'h00AA, 16'h03FF, 1, 10'h0AA));
    vecs.push_back(mk(1, 1, 16'd3,    16'h00FF, 16'h0000, 1, 10'h055));
    vecs.push_back(mk(1, 0, 16'd2,    16'h0001, 16'h0000, 0, 10'h055));
    vecs.push_back(mk(0, 1, 16'd2,    16'h0000, 16'h0000, 1, 10'h055));
    vecs.push_back(mk(1, 0, 16'd3,    16'h03FF, 16'h0000, 0, 10'h3AA));
    vecs.push_back(mk(0, 1, 16'd1,    16'h0000, 16'h03AA, 1, 10'h3AA));

    pats = '{10'h000, 10'h3FF, 10'h155, 10'h2AA, 10'h001,
             10'h200, 10'h0F0, 10'h30F, 10'h1C3, 10'h2A5};

    @(negedge clk);
    reset_seq(10'h2A5, "reset");

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

    // Three-cycle glitch must not reach stable or set CHG.
    sw = 10'h3FF;
    repeat (3) @(negedge clk);
    sw = 10'h2A5;
    repeat (12) @(negedge clk);
    bus_read(16'd0, rd, vld);
    check_output("glitch_swval", rd, 16'h02A5);
    bus_read(16'd2, rd, vld);
    check_output("glitch_chg", rd, 16'h0000);

    // Firmware-style copy loop: poll SW_VAL, write it to LED.
    for (int p = 0; p < 10; p++) begin
      sw = pats[p];
      found = 1'b0;
      for (int it = 0; it < 10 && !found; it++) begin
        bus_read(16'd0, rd, vld);
        if (vld) bus_write(16'd1, rd);
        if (led == pats[p]) found = 1'b1;
      end
      check_output($sformatf("fw_copy%0d", p), 16'(led), 16'(pats[p]));
    end

    // Acceptance on the same edge as a CHG write-1-clear.
    bus_write(16'd2, 16'h0001);
    bus_read(16'd2, rd, vld);
    check_output("race_pre_clear", rd, 16'h0000);
    sw = 10'h0F0;
    repeat (6) @(negedge clk);
    bus.addr = BASE + 16'd2; bus.wdata = 16'h0001; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
    bus_read(16'd2, rd, vld);
    check_output("race_set_wins", rd, 16'h0001);
    bus_write(16'd2, 16'h0001);
    bus_read(16'd2, rd, vld);
    check_output("race_second_clear", rd, 16'h0000);
    bus_read(16'd0, rd, vld);
    check_output("race_swval", rd, 16'h00F0);

    // Interrupt timing (IE only exists with the feature built in).
    bus_write(16'd2, 16'h0002);
    bus_read(16'd2, rd, vld);
    check_output("ie_readback", rd, {14'b0, EXP_IE, 1'b0});
    check_output("irq_idle", 16'(irq), 16'h0);
    sw = 10'h30F;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 7) check_output("irq_e7", 16'(irq), 16'h0);
      if (k == 8) check_output("irq_e8", 16'(irq), 16'(EXP_IE));
    end
    @(negedge clk);
    bus.addr = BASE + 16'd2; bus.wdata = 16'h0003; bus.we = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.we = 1'b0;
    @(posedge clk); #1;
    check_output("irq_after_w1c", 16'(irq), 16'h0);
    @(negedge clk);
    bus_write(16'd2, 16'h0000);

    // Reset in the middle of a pending switch change.
    sw = 10'h3FF;
    repeat (3) @(negedge clk);
    reset_seq(10'h3FF, "midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
